fifo_sync_flex: RTL and testbench

Parametrised single-clock FIFO, the successor to the basic synchronous FIFO. Adds:
- occupancy count
- programmable almost-full and almost-empty thresholds
- overflow and underflow error pulses
- selectable read mode: registered read or first-word-fall-through (FWFT)

Used as the general-purpose rate buffer between producer and consumer datapaths in the same clock domain.

---
 rtl/fifo_defs.sv | 15 +
 rtl/fifo_sync_ram.sv | 29 ++
 rtl/fifo_sync_flex.sv | 83 ++++++++
 tb/tb_fifo_sync_flex.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_defs.sv
// Shared definitions for the fifo_sync_flex family: read-mode constants and
// the width helper used to size pointers and the occupancy count.
package fifo_defs;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read,
// synchronous clear of every entry.
module fifo_sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, overflow/underflow pulses and registered or FWFT read.
module fifo_sync_flex
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0,
  localparam int CW        = fifo_clog2(DEPTH + 1),
  localparam int AW        = fifo_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  wr_acc, rd_acc;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  assign rd_acc     = read_en & ~empty;
  assign wr_acc     = write_en & (~full | rd_acc);
  assign count_next = count + CW'(wr_acc) - CW'(rd_acc);

  fifo_sync_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk  (clk),
    .clear(reset),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout_r       <= '0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (wr_acc) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (rd_acc) dout_r <= rd_data;
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CW'(DEPTH));
      almost_full  <= (count_next >= CW'(AF_LEVEL));
      almost_empty <= (count_next <= CW'(AE_LEVEL));
      overflow     <= write_en & ~wr_acc;
      underflow    <= read_en & ~rd_acc;
    end
  end

  assign data_out = (FWFT == FIFO_MODE_FWFT) ? rd_data : dout_r;

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: a registered-read and an FWFT instance share the
// same stimulus and are both checked against one queue-based model.
module tb_fifo_sync_flex;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_en;
  logic [DW-1:0] data_in;
  logic          read_en;

  logic [DW-1:0] dout0, dout1;
  logic          empty0, empty1, full0, full1, af0, af1, ae0, ae1;
  logic [3:0]    cnt0, cnt1;
  logic          ovf0, ovf1, udf0, udf1;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf, exp_udf;

  always #5 clk = ~clk;

  fifo_sync_flex #(.DATA_WIDTH(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_reg (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(dout0), .empty(empty0), .full(full0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  fifo_sync_flex #(.DATA_WIDTH(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(dout1), .empty(empty1), .full(full1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count_reg"},  32'(cnt0), 32'(n));
    chk({tag, ":count_fwft"}, 32'(cnt1), 32'(n));
    chk({tag, ":empty_reg"},  32'(empty0), 32'(n == 0));
    chk({tag, ":empty_fwft"}, 32'(empty1), 32'(n == 0));
    chk({tag, ":full_reg"},   32'(full0), 32'(n == D));
    chk({tag, ":full_fwft"},  32'(full1), 32'(n == D));
    chk({tag, ":af_reg"},     32'(af0), 32'(n >= AF));
    chk({tag, ":af_fwft"},    32'(af1), 32'(n >= AF));
    chk({tag, ":ae_reg"},     32'(ae0), 32'(n <= AE));
    chk({tag, ":ae_fwft"},    32'(ae1), 32'(n <= AE));
    chk({tag, ":ovf_reg"},    32'(ovf0), 32'(exp_ovf));
    chk({tag, ":ovf_fwft"},   32'(ovf1), 32'(exp_ovf));
    chk({tag, ":udf_reg"},    32'(udf0), 32'(exp_udf));
    chk({tag, ":udf_fwft"},   32'(udf1), 32'(exp_udf));
    chk({tag, ":dout_reg"},   32'(dout0), 32'(exp_dout));
    if (n > 0) chk({tag, ":dout_fwft"}, 32'(dout1), 32'(q[0]));
  endtask

  // One clock with the given requests; the model decides acceptance from pre-edge occupancy.
  task automatic step(input string tag, input logic we, input logic [DW-1:0] d, input logic re);
    bit was_full, was_empty, rd, wr;
    write_en  = we;
    data_in   = d;
    read_en   = re;
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    rd = re && !was_empty;
    wr = we && (!was_full || rd);
    @(posedge clk);
    if (rd) exp_dout = q.pop_front();
    if (wr) q.push_back(d);
    exp_ovf = we && !wr;
    exp_udf = re && !rd;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic we);
    reset    = 1'b1;
    write_en = we;
    data_in  = 8'hEE;
    read_en  = 1'b0;
    @(posedge clk);
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    #1;
    check_all(tag);
    chk({tag, ":dout_fwft_zero"}, 32'(dout1), 32'h0);
    reset    = 1'b0;
    write_en = 1'b0;
  endtask

  initial begin
    int pw, pr;
    reset = 1'b1; write_en = 1'b0; data_in = '0; read_en = 1'b0;
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    @(posedge clk);
    do_reset("reset", 1'b0);

    // Basic ordering and almost_empty return.
    for (int i = 1; i <= 5; i++) step("basic_wr", 1'b1, DW'(i * 10), 1'b0);
    for (int i = 0; i < 3; i++) step("basic_rd", 1'b0, '0, 1'b1);
    chk("basic_last_dout", 32'(dout0), 32'd30);
    chk("basic_count2", 32'(cnt0), 32'd2);
    step("basic_drain", 1'b0, '0, 1'b1);
    step("basic_drain", 1'b0, '0, 1'b1);

    // Fill past full.
    for (int i = 1; i <= 9; i++) step("fill_wr", 1'b1, DW'(i), 1'b0);
    chk("fill_ovf_pulse", 32'(ovf0), 32'd1);
    step("fill_idle", 1'b0, '0, 1'b0);
    chk("fill_ovf_cleared", 32'(ovf0), 32'd0);

    // Full: simultaneous write+read keeps count at DEPTH.
    step("full_wr_rd", 1'b1, 8'hAA, 1'b1);
    chk("full_wr_rd_count", 32'(cnt0), 32'd8);
    for (int i = 0; i < 8; i++) step("full_drain", 1'b0, '0, 1'b1);
    chk("full_last_AA", 32'(dout0), 32'hAA);

    // Empty: simultaneous write+read accepts only the write.
    step("empty_wr_rd", 1'b1, 8'h33, 1'b1);
    chk("empty_wr_rd_udf", 32'(udf0), 32'd1);
    step("empty_drain", 1'b0, '0, 1'b1);

    // Wrap-around at steady occupancy of 3.
    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, DW'(100 + i), 1'b0);
    for (int i = 3; i < 23; i++) step("wrap", 1'b1, DW'(100 + i), 1'b1);
    for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, '0, 1'b1);

    // FWFT fall-through into an empty FIFO.
    step("fwft_wr", 1'b1, 8'h5A, 1'b0);
    chk("fwft_visible", 32'(dout1), 32'h5A);
    step("fwft_pop", 1'b0, '0, 1'b1);
    chk("fwft_empty", 32'(empty1), 32'd1);

    // Reset mid-operation, with a write request held during reset.
    for (int i = 0; i < 5; i++) step("mid_fill", 1'b1, DW'(200 + i), 1'b0);
    do_reset("mid_reset", 1'b1);
    step("post_reset_rd", 1'b0, '0, 1'b1);

    // Randomized traffic in phases of different write/read bias.
    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      pr = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
      for (int i = 0; i < 150; i++)
        step("rand", ($urandom % 100) < pw, DW'($urandom), ($urandom % 100) < pr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
